// File: rtl/div_reconstruct_checker.sv
// Rebuilds n_rec = q*d + r with a W-step shift-add multiplier and compares it to the dividend.
// It accumulates a saturating sum of squared errors and a sample count for in-system MSE measurement.
//
// state   | meaning
// S_IDLE  | waiting for start, ready high
// S_RUN   | W shift-add steps, step counter r_i 0..W-1
// S_CHECK | register n_rec/abs_err/mismatch, update statistics
// S_DONE  | done pulse, ready high, can accept back-to-back
module div_reconstruct_checker #(
  parameter int W     = 8,
  parameter int SSE_W = 40,
  parameter int CNT_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [W-1:0]       i_q,
  input  logic [W-1:0]       i_d,
  input  logic [W-1:0]       i_r,
  input  logic [2*W-1:0]     i_n,
  input  logic               i_clr_stats,
  output logic               o_ready,
  output logic               o_done,
  output logic [2*W-1:0]     o_n_rec,
  output logic [2*W-1:0]     o_abs_err,
  output logic               o_mismatch,
  output logic [SSE_W-1:0]   o_sse,
  output logic [CNT_W-1:0]   o_count
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_last_step;

  logic [IW-1:0]    r_i;
  logic [2*W-1:0]   r_acc;
  logic [2*W-1:0]   r_mcand;
  logic [W-1:0]     r_mplier;
  logic [2*W-1:0]   r_nreg;

  logic [2*W-1:0]   r_n_rec;
  logic [2*W-1:0]   r_abs_err;
  logic             r_mismatch;
  logic [SSE_W-1:0] r_sse;
  logic [CNT_W-1:0] r_count;

  logic [2*W-1:0]   w_abs;
  logic [4*W-1:0]   w_sq;
  logic [SSE_W:0]   w_sse_sum;

  assign w_last_step = (r_i == IW'(W - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_RUN;
      S_RUN:   if (w_last_step) w_state_next = S_CHECK;
      S_CHECK: w_state_next = S_DONE;
      S_DONE:  w_state_next = i_start ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready  = 1'b0;
    o_done   = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready  = 1'b1;
        w_accept = i_start;
      end
      S_DONE: begin
        o_ready  = 1'b1;
        o_done   = 1'b1;
        w_accept = i_start;
      end
      default: ;
    endcase
  end

  // Shift-add datapath: 2W bits hold (2^W-1)^2 + (2^W-1) without carry-out.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_i      <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_nreg   <= '0;
    end else if (w_accept) begin
      r_i      <= '0;
      r_acc    <= {{W{1'b0}}, i_r};
      r_mcand  <= {{W{1'b0}}, i_d};
      r_mplier <= i_q;
      r_nreg   <= i_n;
    end else if (r_state == S_RUN) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_i      <= r_i + 1'b1;
    end
  end

  assign w_abs     = (r_acc > r_nreg) ? (r_acc - r_nreg) : (r_nreg - r_acc);
  assign w_sq      = (4*W)'(w_abs) * (4*W)'(w_abs);
  assign w_sse_sum = {1'b0, r_sse} + (SSE_W+1)'(w_sq);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_n_rec    <= '0;
      r_abs_err  <= '0;
      r_mismatch <= 1'b0;
    end else if (r_state == S_CHECK) begin
      r_n_rec    <= r_acc;
      r_abs_err  <= w_abs;
      r_mismatch <= |w_abs;
    end
  end

  // A clear in the CHECK cycle wins over accumulating that sample.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr_stats) begin
      r_sse   <= '0;
      r_count <= '0;
    end else if (r_state == S_CHECK) begin
      r_sse <= w_sse_sum[SSE_W] ? '1 : w_sse_sum[SSE_W-1:0];
      if (r_count != '1) r_count <= r_count + 1'b1;
    end
  end

  assign o_n_rec    = r_n_rec;
  assign o_abs_err  = r_abs_err;
  assign o_mismatch = r_mismatch;
  assign o_sse      = r_sse;
  assign o_count    = r_count;

endmodule
